fc_act_reader: RTL and testbench
================================

Name: fc_act_reader

Overview:
- Reader side of the activation SRAM that the fully-connected stage writes into.
- Fetches packed activation words (ACT_PER_ADDR pixels of BW_PER_ACT bits each) from a 1-cycle-latency SRAM.
- Unpacks the words into a gap-free stream of single pixels, driving f0 and fc_enable of the FC accumulator.
- Prefetches through a 2-slot word buffer so the stream never bubbles. fc_enable must stay high for exactly act_len contiguous cycles, because the accumulator restarts on its first enable cycle.

Parameters:
- ACT_PER_ADDR, 4, pixels per SRAM word.
- BW_PER_ACT, 12, bits per pixel (signed).
- ADDR_BW, 10, SRAM address width.
- LEN_BW, 7, width of act_len (maximum 64 pixels).

Ports:
- clk  in  1  clock.
- srst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_BW  first word address; latched on start.
- act_len  in  LEN_BW  number of pixels to stream; latched on start.
- sram_ren  out  1  read enable.
- sram_raddr  out  ADDR_BW  read address.
- sram_rdata  in  ACT_PER_ADDR*BW_PER_ACT  read data, valid the cycle after sram_ren.
- f0  out  BW_PER_ACT  signed pixel to FC.
- fc_enable  out  1  pixel-valid / accumulate enable.
- busy  out  1  high from start accept until done.
- done  out  1  one-cycle pulse after the last pixel.

Behaviour:
- Reset (asynchronous, srst_n=0): all outputs 0, state IDLE, buffer empty, in-flight flag clear. Reset mid-stream aborts immediately; no done pulse is produced.
- Pixel order within a word: MSB slice first, i.e. pixel k = rdata[(ACT_PER_ADDR-k)*BW_PER_ACT-1 -: BW_PER_ACT].
- States:
  - IDLE: start=1 with act_len>0 latches the inputs, sets busy, goes to FILL. start=1 with act_len=0 pulses done next cycle and stays IDLE.
  - FILL: issues reads until the buffer plus in-flight count reaches 2 or all words are requested. Goes to STREAM once 2 words are held, or once all words are held (act_len<=4).
  - STREAM: outputs one pixel per cycle. After the pixel count reaches act_len, goes to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Words needed = ceil(act_len/ACT_PER_ADDR). Pixels beyond act_len in the last word are discarded and never appear on f0.
- Read issue rule, evaluated every cycle (registered sram_ren/sram_raddr):
  - Issue when occupied slots + in-flight < 2 and words_requested < words needed.
  - Addresses increment by 1 from base_addr and wrap modulo 2^ADDR_BW.
- Returning data is written to the free slot in the cycle it arrives. A word fully consumed and a word arriving in the same cycle is legal; the slot frees and refills with no bubble.
- Timing, with start accepted at cycle T:
  - sram_ren=1, sram_raddr=base_addr during T+1.
  - Second read during T+2.
  - Data arrives T+2 and T+3.
  - First pixel: f0/fc_enable registered, high from T+4.
  - fc_enable high for exactly act_len consecutive cycles, T+4 … T+3+act_len.
  - done pulses at T+4+act_len; busy falls the same cycle.
- f0 holds the last pixel value when fc_enable=0 (no requirement on its value). fc_enable is never high outside STREAM.
- start while busy is ignored: no re-latch, no effect on the stream.
- Pixel counter width LEN_BW. The word-within and pixel-within counters wrap at ACT_PER_ADDR.

Decomposition:
- Shared package: ACT_PER_ADDR, BW_PER_ACT, ADDR_BW, the state enum (IDLE/FILL/STREAM/DONE), and the word-to-pixel slice function.
- One natural sub-module: fc_word_buf, the 2-slot word FIFO with push/pop/occupancy. The FSM and counters stay in the top.

Test Plan:
- act_len=8, base_addr=5, mem[5]={001,002,003,004}, mem[6]={005,006,007,008} (hex) -> sram_ren at T+1 (addr 5) and T+2 (addr 6); f0 = 1..8 on T+4..T+11 with fc_enable continuous; done at T+12.
- act_len=6, mem[5] as above, mem[6]={FFF,800,7FF,123} -> f0 = 001,002,003,004,FFF(-1),800(-2048); exactly 2 reads; 7FF/123 never driven; fc_enable 6 cycles.
- act_len=48, base_addr=0x3FE -> reads at 3FE,3FF,000,…,009 (12 words, wrap); fc_enable exactly 48 cycles with no gaps; never more than 2 outstanding words.
- act_len=0 -> no sram_ren, no fc_enable, done one cycle after start; a start pulse during busy in the act_len=8 run -> stream unchanged, single done.
- srst_n low during pixel 3 of an act_len=8 run -> all outputs 0 asynchronously, no done; a new start after release streams correctly from base_addr.

Source files
------------

// File: rtl/fc_act_reader_pkg.sv
// Shared definitions for the FC activation reader: geometry of the packed
// activation word, the reader state encoding and the word-to-pixel slicer.
package fc_act_reader_pkg;

    localparam int ACT_PER_ADDR = 4;
    localparam int BW_PER_ACT   = 12;
    localparam int ADDR_BW      = 10;
    localparam int LEN_BW       = 7;
    localparam int WORD_W       = ACT_PER_ADDR * BW_PER_ACT;
    localparam int SUB_W        = $clog2(ACT_PER_ADDR);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } rd_state_e;

    // Pixel k of a word, MSB slice first (pixel 0 sits in the top bits).
    function automatic logic signed [BW_PER_ACT-1:0] act_slice(
        input logic [WORD_W-1:0] word,
        input logic [SUB_W-1:0]  k
    );
        logic [WORD_W-1:0] shifted;
        shifted = word >> ((ACT_PER_ADDR - 1 - int'(k)) * BW_PER_ACT);
        return $signed(shifted[BW_PER_ACT-1:0]);
    endfunction

endpackage

// File: rtl/fc_word_buf.sv
// Two-slot word FIFO sitting between the SRAM read port and the pixel
// unpacker. Push and pop in the same cycle are allowed so a slot can be
// drained and refilled without a bubble.
module fc_word_buf
    import fc_act_reader_pkg::*;
(
    input  logic              clk,
    input  logic              srst_n,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic [1:0]        occ
);

    logic [WORD_W-1:0] slot [2];
    logic              wr_ptr;
    logic              rd_ptr;

    // Pointer and occupancy bookkeeping; the only state cleared by reset.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Word storage; contents are meaningless while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= wdata;
    end

    assign rdata = slot[rd_ptr];

endmodule

// File: rtl/fc_act_reader.sv
// Activation SRAM reader for the fully-connected stage. Fetches packed words,
// keeps up to two words buffered or in flight, and unpacks them into a
// gap-free pixel stream (f0 / fc_enable) of exactly act_len pixels.
module fc_act_reader
    import fc_act_reader_pkg::*;
(
    input  logic                         clk,
    input  logic                         srst_n,
    input  logic                         start,
    input  logic [ADDR_BW-1:0]           base_addr,
    input  logic [LEN_BW-1:0]            act_len,
    output logic                         sram_ren,
    output logic [ADDR_BW-1:0]           sram_raddr,
    input  logic [WORD_W-1:0]            sram_rdata,
    output logic signed [BW_PER_ACT-1:0] f0,
    output logic                         fc_enable,
    output logic                         busy,
    output logic                         done
);

    rd_state_e         state;
    logic [LEN_BW-1:0] len_q;
    logic [LEN_BW-1:0] words_need_q;
    logic [LEN_BW-1:0] words_req;
    logic [LEN_BW-1:0] pix_cnt;
    logic [SUB_W-1:0]  sub_idx;
    logic              rd_pend;

    logic [1:0]        buf_occ;
    logic [WORD_W-1:0] buf_word;

    logic [LEN_BW-1:0] words_need_d;
    logic              fill_ready;
    logic              emit;
    logic              last_pix;
    logic              pop;
    logic [2:0]        in_flight;
    logic              issue;

    // rd_pend marks the cycle the SRAM data is valid, so it doubles as push.
    fc_word_buf u_word_buf (
        .clk    (clk),
        .srst_n (srst_n),
        .push   (rd_pend),
        .wdata  (sram_rdata),
        .pop    (pop),
        .rdata  (buf_word),
        .occ    (buf_occ)
    );

    // Stream bookkeeping: when to start, emit, pop and issue the next read.
    always_comb begin
        words_need_d = LEN_BW'(({1'b0, act_len} + (LEN_BW + 1)'(ACT_PER_ADDR - 1)) >> SUB_W);
        // Start streaming once two words are on hand (or every word, for
        // short runs) so the prefetch can always stay ahead of the unpacker.
        fill_ready   = (buf_occ != 2'd0) &&
                       ((({1'b0, buf_occ} + 3'(rd_pend)) >= 3'd2) ||
                        ((words_req == words_need_q) && !sram_ren && !rd_pend));
        emit         = ((state == FILL) && fill_ready) ||
                       ((state == STREAM) && (pix_cnt != len_q));
        last_pix     = (pix_cnt + LEN_BW'(1)) == len_q;
        pop          = emit && ((sub_idx == SUB_W'(ACT_PER_ADDR - 1)) || last_pix);
        // Words held or owed to the buffer after this edge: occupied slots,
        // the word landing now, the read currently on the bus, less any pop.
        in_flight    = {1'b0, buf_occ} + 3'(rd_pend) + 3'(sram_ren) - 3'(pop);
        issue        = ((state == FILL) || (state == STREAM)) &&
                       (words_req != words_need_q) && (in_flight < 3'd2);
    end

    // Reader FSM with registered SRAM request, pixel output and status.
    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state        <= IDLE;
            len_q        <= '0;
            words_need_q <= '0;
            words_req    <= '0;
            pix_cnt      <= '0;
            sub_idx      <= '0;
            rd_pend      <= 1'b0;
            sram_ren     <= 1'b0;
            sram_raddr   <= '0;
            f0           <= '0;
            fc_enable    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            rd_pend   <= sram_ren;
            done      <= 1'b0;
            sram_ren  <= 1'b0;
            fc_enable <= emit;

            if (issue) begin
                sram_ren   <= 1'b1;
                sram_raddr <= sram_raddr + ADDR_BW'(1);
                words_req  <= words_req + LEN_BW'(1);
            end

            if (emit) begin
                f0      <= act_slice(buf_word, sub_idx);
                pix_cnt <= pix_cnt + LEN_BW'(1);
                sub_idx <= pop ? '0 : sub_idx + SUB_W'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (act_len != '0) begin
                            len_q        <= act_len;
                            words_need_q <= words_need_d;
                            words_req    <= LEN_BW'(1);
                            pix_cnt      <= '0;
                            sub_idx      <= '0;
                            sram_ren     <= 1'b1;
                            sram_raddr   <= base_addr;
                            busy         <= 1'b1;
                            state        <= FILL;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (fill_ready) state <= STREAM;
                end
                STREAM: begin
                    if (!emit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_act_reader.sv
// Directed bench for fc_act_reader: SRAM model with 1-cycle read latency,
// scoreboard queues of expected read addresses and pixels, per-run timing
// checks relative to the start-accept cycle.
module tb_fc_act_reader;
    import fc_act_reader_pkg::*;

    logic                         clk = 1'b0;
    logic                         srst_n;
    logic                         start;
    logic [ADDR_BW-1:0]           base_addr;
    logic [LEN_BW-1:0]            act_len;
    logic                         sram_ren;
    logic [ADDR_BW-1:0]           sram_raddr;
    logic [WORD_W-1:0]            sram_rdata;
    logic signed [BW_PER_ACT-1:0] f0;
    logic                         fc_enable;
    logic                         busy;
    logic                         done;

    fc_act_reader dut (
        .clk        (clk),
        .srst_n     (srst_n),
        .start      (start),
        .base_addr  (base_addr),
        .act_len    (act_len),
        .sram_ren   (sram_ren),
        .sram_raddr (sram_raddr),
        .sram_rdata (sram_rdata),
        .f0         (f0),
        .fc_enable  (fc_enable),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [WORD_W-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (sram_ren) sram_rdata <= mem[sram_raddr];
    end

    int n_assert = 0;
    int n_fail   = 0;

    int                 exp_pix [$];
    logic [ADDR_BW-1:0] exp_addr [$];

    int en_cnt, first_en, last_en;
    int rd_cnt, first_rd;
    int done_cnt, done_cyc;
    int max_out;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [WORD_W-1:0] pack4(input int a, input int b,
                                                input int c, input int d);
        return {a[11:0], b[11:0], c[11:0], d[11:0]};
    endfunction

    task automatic clear_counts();
        en_cnt = 0; first_en = -1; last_en = -1;
        rd_cnt = 0; first_rd = -1;
        done_cnt = 0; done_cyc = -1;
        max_out = 0;
    endtask

    task automatic sample();
        int e;
        int outst;
        logic [ADDR_BW-1:0] a;
        if (fc_enable) begin
            en_cnt++;
            if (first_en < 0) first_en = cyc;
            last_en = cyc;
            check("busy_with_enable", busy, 1);
            if (exp_pix.size() == 0) check("extra_pixel", 1, 0);
            else begin
                e = exp_pix.pop_front();
                check("f0", f0, e);
            end
        end
        if (sram_ren) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
            if (exp_addr.size() == 0) check("extra_read", 1, 0);
            else begin
                a = exp_addr.pop_front();
                check("sram_raddr", sram_raddr, a);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_at_done", busy, 0);
        end
        outst = rd_cnt - en_cnt / ACT_PER_ADDR;
        if (outst > max_out) max_out = outst;
    endtask

    task automatic cycle();
        @(negedge clk);
        sample();
    endtask

    task automatic run(input logic [ADDR_BW-1:0] base, input logic [LEN_BW-1:0] len,
                       input int words, input bit poke);
        int t0;
        int n;
        clear_counts();
        cycle();
        start = 1'b1; base_addr = base; act_len = len; t0 = cyc;
        cycle();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            cycle();
            n++;
            start = poke && (cyc == t0 + 6);
            if (start) begin
                base_addr = '0;
                act_len   = LEN_BW'(4);
            end
        end
        start = 1'b0;
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (4) cycle();
        check("done_count", done_cnt, 1);
        check("read_count", rd_cnt, words);
        check("pixel_count", en_cnt, int'(len));
        check("scoreboard_left", exp_pix.size() + exp_addr.size(), 0);
        check("outstanding_le_2", max_out <= 2, 1);
        check("idle_busy", busy, 0);
        if (len != '0) begin
            check("first_read_cycle", first_rd, t0 + 1);
            check("first_pixel_cycle", first_en, t0 + 4);
            check("enable_contiguous", last_en - first_en + 1, int'(len));
            check("done_cycle", done_cyc, t0 + 4 + int'(len));
        end else begin
            check("zero_len_done_cycle", done_cyc, t0 + 1);
        end
    endtask

    task automatic load_ab();
        mem[5] = pack4(1, 2, 3, 4);
        mem[6] = pack4(5, 6, 7, 8);
        exp_addr.push_back(ADDR_BW'(5));
        exp_addr.push_back(ADDR_BW'(6));
        for (int i = 1; i <= 8; i++) exp_pix.push_back(i);
    endtask

    initial begin
        int t0;
        logic [ADDR_BW-1:0] wa;
        int v [4];

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        srst_n = 1'b0; start = 1'b0; base_addr = '0; act_len = '0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("rst_sram_ren", sram_ren, 0);
        check("rst_sram_raddr", sram_raddr, 0);
        check("rst_f0", f0, 0);
        check("rst_fc_enable", fc_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        srst_n = 1'b1;

        // act_len=8 from address 5, with a start pulse while busy
        load_ab();
        run(ADDR_BW'(5), LEN_BW'(8), 2, 1'b1);

        // act_len=6: trailing two pixels of the second word are discarded
        mem[6] = pack4(-1, -2048, 2047, 'h123);
        exp_addr.push_back(ADDR_BW'(5));
        exp_addr.push_back(ADDR_BW'(6));
        for (int i = 1; i <= 4; i++) exp_pix.push_back(i);
        exp_pix.push_back(-1);
        exp_pix.push_back(-2048);
        run(ADDR_BW'(5), LEN_BW'(6), 2, 1'b0);

        // act_len=48 with the address wrapping past 0x3FF
        for (int w = 0; w < 12; w++) begin
            wa = ADDR_BW'(10'h3FE + w);
            for (int k = 0; k < 4; k++) v[k] = (w * 4 + k) * 85 - 2000;
            mem[wa] = pack4(v[0], v[1], v[2], v[3]);
            exp_addr.push_back(wa);
            for (int k = 0; k < 4; k++) exp_pix.push_back(v[k]);
        end
        run(ADDR_BW'(10'h3FE), LEN_BW'(48), 12, 1'b0);

        // act_len=0: immediate done, no traffic
        run(ADDR_BW'(5), LEN_BW'(0), 0, 1'b0);

        // reset while the third pixel is on f0
        clear_counts();
        load_ab();
        cycle();
        start = 1'b1; base_addr = ADDR_BW'(5); act_len = LEN_BW'(8); t0 = cyc;
        cycle();
        start = 1'b0;
        while (cyc < t0 + 6) cycle();
        check("pre_abort_pixels", en_cnt, 3);
        srst_n = 1'b0;
        #1;
        check("abort_sram_ren", sram_ren, 0);
        check("abort_sram_raddr", sram_raddr, 0);
        check("abort_f0", f0, 0);
        check("abort_fc_enable", fc_enable, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        done_cnt = 0;
        repeat (3) cycle();
        srst_n = 1'b1;
        repeat (3) cycle();
        check("no_done_after_abort", done_cnt, 0);
        exp_pix.delete();
        exp_addr.delete();

        // fresh run after release streams from base_addr again
        load_ab();
        run(ADDR_BW'(5), LEN_BW'(8), 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
